// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : fetch port, data port and byte-lane bank bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    // Fetch port
    logic                    IReq;
    logic [31:0]             IAddr;
    logic                    IGnt;
    logic                    IValid;
    logic                    IErr;
    logic [31:0]             IData;

    // Data port
    logic                    DReq;
    logic [5:0]              DOpcode;
    logic [31:0]             DAddr;
    logic [31:0]             DWData;
    logic                    DGnt;
    logic                    DValid;
    logic                    DErr;
    logic [31:0]             DRData;

    // Load formatting side-band
    logic [1:0]              MemSel;
    logic [5:0]              LdOpcode;

    // Byte-lane banks
    logic [ADDR_WIDTH-1:0]   BankAddr;
    logic [3:0]              BankWe;
    logic [4*DATA_WIDTH-1:0] BankWData;
    logic [DATA_WIDTH-1:0]   Bank0Out;
    logic [DATA_WIDTH-1:0]   Bank1Out;
    logic [DATA_WIDTH-1:0]   Bank2Out;
    logic [DATA_WIDTH-1:0]   Bank3Out;

    modport slave (
        input  IReq, IAddr,
        output IGnt, IValid, IErr, IData,
        input  DReq, DOpcode, DAddr, DWData,
        output DGnt, DValid, DErr, DRData,
        output MemSel, LdOpcode,
        output BankAddr, BankWe, BankWData,
        input  Bank0Out, Bank1Out, Bank2Out, Bank3Out
    );

    modport master (
        output IReq, IAddr,
        input  IGnt, IValid, IErr, IData,
        output DReq, DOpcode, DAddr, DWData,
        input  DGnt, DValid, DErr, DRData,
        input  MemSel, LdOpcode,
        input  BankAddr, BankWe, BankWData,
        output Bank0Out, Bank1Out, Bank2Out, Bank3Out
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-port (fetch/data) arbiter onto four synchronous byte banks
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 2
) (
    input  wire logic     Clk,
    input  wire logic     Rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int c_AW    = ADDR_WIDTH + 2;
    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SH  = 6'h29;
    localparam logic [5:0] c_OP_SW  = 6'h2B;

    logic [1:0]         r_state;
    logic               r_win_i;
    logic [c_AW-1:0]    r_addr;
    logic [5:0]         r_opcode;
    logic [31:0]        r_wdata;
    logic [c_CNT_W-1:0] r_starve;
    logic [1:0]         r_memsel;
    logic [5:0]         r_ldop;

    logic                    w_can_gnt;
    logic                    w_starved;
    logic                    w_i_gnt;
    logic                    w_d_gnt;
    logic                    w_in_acc;
    logic                    w_in_resp;
    logic                    w_is_load;
    logic                    w_is_store;
    logic                    w_bad_op;
    logic                    w_misalign;
    logic                    w_err;
    logic                    w_do_write;
    logic [3:0]              w_mask;
    logic [4*DATA_WIDTH-1:0] w_wd_ext;
    logic [4*DATA_WIDTH-1:0] w_store_data;
    logic [31:0]             w_rdata;

    // Grants are gated by Rst_n so every output reads 0 while reset is held.
    assign w_can_gnt = Rst_n && ((r_state == c_IDLE) || (r_state == c_RESP));
    assign w_starved = (r_starve == c_CNT_W'(STARVE_LIMIT));
    assign w_i_gnt   = w_can_gnt && bus.IReq && (!bus.DReq || w_starved);
    assign w_d_gnt   = w_can_gnt && bus.DReq && !w_i_gnt;

    assign w_in_acc  = (r_state == c_ACC);
    assign w_in_resp = (r_state == c_RESP);
    assign w_wd_ext  = (4*DATA_WIDTH)'(r_wdata);

    always_comb begin
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_bad_op     = 1'b0;
        w_misalign   = 1'b0;
        w_mask       = 4'b0000;
        w_store_data = '0;
        if (r_win_i) begin
            w_misalign = (r_addr[1:0] != 2'b00);
        end else begin
            case (r_opcode)
                c_OP_LW: begin
                    w_is_load  = 1'b1;
                    w_misalign = (r_addr[1:0] != 2'b00);
                end
                c_OP_LBU: begin
                    w_is_load = 1'b1;
                end
                c_OP_LHU: begin
                    w_is_load  = 1'b1;
                    w_misalign = r_addr[0];
                end
                c_OP_SB: begin
                    w_is_store   = 1'b1;
                    w_mask       = 4'b0001 << r_addr[1:0];
                    w_store_data = {4{w_wd_ext[DATA_WIDTH-1:0]}};
                end
                c_OP_SH: begin
                    w_is_store   = 1'b1;
                    w_misalign   = r_addr[0];
                    w_mask       = r_addr[1] ? 4'b1100 : 4'b0011;
                    w_store_data = {2{w_wd_ext[2*DATA_WIDTH-1:0]}};
                end
                c_OP_SW: begin
                    w_is_store   = 1'b1;
                    w_misalign   = (r_addr[1:0] != 2'b00);
                    w_mask       = 4'b1111;
                    w_store_data = w_wd_ext;
                end
                default: begin
                    w_bad_op = 1'b1;
                end
            endcase
        end
    end

    assign w_err      = w_bad_op || w_misalign;
    assign w_do_write = w_in_acc && w_is_store && !w_err;
    assign w_rdata    = 32'({bus.Bank3Out, bus.Bank2Out, bus.Bank1Out, bus.Bank0Out});

    assign bus.IGnt      = w_i_gnt;
    assign bus.DGnt      = w_d_gnt;
    assign bus.BankAddr  = w_in_acc ? r_addr[c_AW-1:2] : '0;
    assign bus.BankWe    = w_do_write ? w_mask : 4'b0000;
    assign bus.BankWData = w_do_write ? w_store_data : '0;
    assign bus.IErr      = w_in_acc && r_win_i && w_err;
    assign bus.DErr      = w_in_acc && !r_win_i && w_err;
    assign bus.IValid    = w_in_resp && r_win_i;
    assign bus.DValid    = w_do_write || (w_in_resp && !r_win_i);
    assign bus.IData     = (w_in_resp && r_win_i) ? w_rdata : 32'h0;
    assign bus.DRData    = (w_in_resp && !r_win_i) ? w_rdata : 32'h0;
    assign bus.MemSel    = r_memsel;
    assign bus.LdOpcode  = r_ldop;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= c_IDLE;
            r_win_i  <= 1'b0;
            r_addr   <= '0;
            r_opcode <= 6'h00;
            r_wdata  <= 32'h0;
            r_memsel <= 2'b00;
            r_ldop   <= 6'h00;
        end else begin
            case (r_state)
                c_IDLE, c_RESP: begin
                    if (w_i_gnt || w_d_gnt) begin
                        r_state  <= c_ACC;
                        r_win_i  <= w_i_gnt;
                        r_addr   <= w_i_gnt ? bus.IAddr[c_AW-1:0] : bus.DAddr[c_AW-1:0];
                        r_opcode <= w_i_gnt ? 6'h00 : bus.DOpcode;
                        r_wdata  <= bus.DWData;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_ACC: begin
                    if (!w_err && (r_win_i || w_is_load)) begin
                        r_state <= c_RESP;
                    end else begin
                        r_state <= c_IDLE;
                    end
                    // Load-format side-band follows data loads only; fetches leave it alone.
                    if (!w_err && w_is_load) begin
                        r_memsel <= r_addr[1:0];
                        r_ldop   <= r_opcode;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_starve <= '0;
        end else if (w_i_gnt || !bus.IReq) begin
            r_starve <= '0;
        end else if (w_d_gnt) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the width of one memory byte lane.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, setting the bank word-address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 2, setting the maximum consecutive data grants while IReq is pending.
REQ-004 The block SHALL have ports Clk (in, 1, the single clock) and Rst_n (in, 1, asynchronous active-low reset).
REQ-005 The block SHALL have ports IReq (in, 1), IAddr (in, 32), IGnt (out, 1), IValid (out, 1), IErr (out, 1) and IData (out, 32) forming the fetch port.
REQ-006 The block SHALL have ports DReq (in, 1), DOpcode (in, 6), DAddr (in, 32), DWData (in, 32), DGnt (out, 1), DValid (out, 1), DErr (out, 1) and DRData (out, 32) forming the data port.
REQ-007 The block SHALL have ports MemSel (out, 2) and LdOpcode (out, 6) feeding load formatting, held with DRData.
REQ-008 The block SHALL have ports BankAddr (out, ADDR_WIDTH), BankWe (out, 4, one per lane), BankWData (out, 4*DATA_WIDTH) and Bank0Out..Bank3Out (in, DATA_WIDTH each) connecting to the four byte-lane banks.

Function
REQ-009 The block SHALL recognise opcodes lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29 and sw 0x2B; any other DOpcode SHALL be an error.
REQ-010 The FSM SHALL have states IDLE, ACC and RESP; grants SHALL be issued only in IDLE or RESP, never in ACC.
REQ-011 Grant SHALL be combinational in the request cycle T; on the T edge, address, opcode, write data and winner SHALL be latched and the state SHALL go to ACC.
REQ-012 In ACC (T+1), BankAddr SHALL be the latched addr[ADDR_WIDTH+1:2], and BankWe SHALL be the store lane mask or 0000 for loads, fetches and errors.
REQ-013 ACC SHALL transition to RESP for a valid load or fetch, and to IDLE for a store or error.
REQ-014 In RESP (T+2), the winner's data output SHALL equal {Bank3Out,Bank2Out,Bank1Out,Bank0Out}, and IValid or DValid SHALL pulse high for exactly one cycle.
REQ-015 MemSel SHALL equal latched DAddr[1:0] and LdOpcode SHALL equal latched DOpcode, both held from RESP until the next data load reaches RESP.
REQ-016 A valid store SHALL pulse DValid in its ACC cycle.
REQ-017 Store lanes SHALL be: sb sets lane DAddr[1:0] only; sh sets lanes 1:0 if DAddr[1]=0, else lanes 3:2; sw sets all four lanes.
REQ-018 BankWData SHALL be the byte replicated ×4 for sb, the halfword replicated ×2 for sh, and DWData for sw.
REQ-019 A misaligned access (lhu/sh with addr[0]=1, lw/sw with addr[1:0]≠0, or IAddr[1:0]≠0) SHALL still be granted, SHALL pulse DErr/IErr in ACC, SHALL perform no write and SHALL assert no Valid.
REQ-020 When only one Req is high, that port SHALL win.
REQ-021 When both Req are high, D SHALL win unless the starvation counter equals STARVE_LIMIT, in which case I SHALL win and the counter SHALL clear.
REQ-022 The starvation counter SHALL increment on each DGnt while IReq=1, and SHALL clear on IGnt or on any cycle with IReq=0.
REQ-023 Requesters SHALL hold Req and request inputs until Gnt; the block SHALL sample them only in the grant cycle.
REQ-024 Back-to-back accesses SHALL be supported: a grant in RESP SHALL move the state to ACC, giving a peak rate of one load per 2 cycles.

Reset
REQ-025 On Rst_n=0 the block SHALL asynchronously force state IDLE, starvation counter 0, and all outputs to 0 (including BankWe=0000, MemSel=00, LdOpcode=0).
REQ-026 A reset during ACC or RESP SHALL abandon the access, with no write and no Valid after Rst_n deasserts.
REQ-027 In the first cycle after reset release the block SHALL be in IDLE and able to grant.

Verification
REQ-028 Verification SHALL cover: DReq lw at DAddr 0x10, banks 0x44/33/22/11 -> DGnt at T, BankAddr=4 at T+1, DValid at T+2 with DRData=0x44332211 and MemSel=00.
REQ-029 Verification SHALL cover: sb at DAddr 0x7, DWData 0xAB -> BankWe=1000 and BankWData=0xABABABAB at T+1, DValid at T+1, state IDLE at T+2.
REQ-030 Verification SHALL cover: sh at DAddr 0x3 -> DErr at T+1, BankWe=0000 and no DValid; lw at DAddr 0x2 -> DErr at T+1.
REQ-031 Verification SHALL cover: IReq and DReq both held continuously with STARVE_LIMIT=2 -> grant order D, D, I, D, D, I.
REQ-032 Verification SHALL cover: Rst_n low in the ACC cycle of an sw -> BankWe=0000 immediately, and no DValid.
REQ-033 Verification SHALL cover: a fetch at IAddr 0x20 granted in the RESP cycle of a prior lbu -> IValid two cycles later, with MemSel/LdOpcode still holding the lbu values.
